// File: rtl/mbist_march_y_ctrl.sv
// March Y MBIST controller for a synchronous single-port memory.
// Sequence: up(w0); up(r0,w1,r1); down(r1,w0,r0); up(r0), then a drain cycle
// for the last read compare. Optional first-failure log enabled by the
// MBIST_FAIL_LOG_EN macro; without it fail_elem/fail_addr/fail_data read 0.
module mbist_march_y_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] CA,
   output logic                  we,
   output logic [DATA_WIDTH-1:0] datain,
   output logic                  re,
   input  logic [DATA_WIDTH-1:0] dataout,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [1:0]            fail_elem,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_M0    = 3'd1;
   localparam logic [2:0] S_M1    = 3'd2;
   localparam logic [2:0] S_M2    = 3'd3;
   localparam logic [2:0] S_M3    = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] ONES     = '1;
   localparam logic [DATA_WIDTH-1:0] ZEROS    = '0;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  chk_q;
   logic [DATA_WIDTH-1:0] exp_q;
   logic                  fail_q;

   logic                  wr, rd, multi_op, last_addr, start_acc, mismatch;
   logic [DATA_WIDTH-1:0] wval, rval;
   logic [2:0]            next_elem;

   assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign mismatch  = chk_q && (dataout != exp_q);

   // Decode the single op issued this cycle and its write / expected-read value.
   always_comb begin
      wr       = 1'b0;
      rd       = 1'b0;
      wval     = ZEROS;
      rval     = ZEROS;
      multi_op = 1'b0;
      case (state_q)
         S_M0: wr = 1'b1;
         S_M1: begin
            multi_op = 1'b1;
            case (op_q)
               2'd0:    rd = 1'b1;
               2'd1:    begin wr = 1'b1; wval = ONES; end
               default: begin rd = 1'b1; rval = ONES; end
            endcase
         end
         S_M2: begin
            multi_op = 1'b1;
            case (op_q)
               2'd0:    begin rd = 1'b1; rval = ONES; end
               2'd1:    wr = 1'b1;
               default: rd = 1'b1;
            endcase
         end
         S_M3: rd = 1'b1;
         default: ;
      endcase
   end

   // Sequence ops, addresses and elements; M2 stops at 0 so the counter never wraps.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      op_d      = op_q;
      last_addr = (state_q == S_M2) ? (addr_q == '0) : (addr_q == ADDR_MAX);
      next_elem = state_q + 3'd1;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_M0;
               addr_d  = '0;
               op_d    = 2'd0;
            end
         end
         S_M0, S_M1, S_M2, S_M3: begin
            if (multi_op && (op_q != 2'd2)) begin
               op_d = op_q + 2'd1;
            end else begin
               op_d = 2'd0;
               if (last_addr) begin
                  state_d = next_elem;
                  addr_d  = (state_q == S_M1) ? ADDR_MAX : '0;
               end else if (state_q == S_M2) begin
                  addr_d = addr_q - ADDR_ONE;
               end else begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         op_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   // Write data holds its last value outside write cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= datain;
   end

   // Read compare pipeline and sticky fail flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q  <= 1'b0;
         exp_q  <= '0;
         fail_q <= 1'b0;
      end else begin
         chk_q <= rd;
         exp_q <= rval;
         if (start_acc)     fail_q <= 1'b0;
         else if (mismatch) fail_q <= 1'b1;
      end
   end

`ifdef MBIST_FAIL_LOG_EN
   logic [1:0]            elem;
   logic [1:0]            chk_elem_q, fail_elem_q;
   logic [ADDR_WIDTH-1:0] chk_addr_q, fail_addr_q;
   logic [DATA_WIDTH-1:0] fail_data_q;

   assign elem = 2'(state_q - S_M0);

   // Capture element/address/data of the first mismatch only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_elem_q  <= '0;
         chk_addr_q  <= '0;
         fail_elem_q <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         chk_elem_q <= elem;
         chk_addr_q <= addr_q;
         if (start_acc) begin
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
         end else if (mismatch && !fail_q) begin
            fail_elem_q <= chk_elem_q;
            fail_addr_q <= chk_addr_q;
            fail_data_q <= dataout;
         end
      end
   end

   assign fail_elem = fail_elem_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
`else
   assign fail_elem = '0;
   assign fail_addr = '0;
   assign fail_data = '0;
`endif

   assign CA     = addr_q;
   assign we     = wr;
   assign re     = rd;
   assign datain = wr ? wval : hold_q;
   assign busy   = (state_q >= S_M0) && (state_q <= S_DRAIN);
   assign done   = (state_q == S_DONE);
   assign fail   = fail_q;

endmodule

// File: tb/tb_mbist_march_y_ctrl.sv
// Bench for mbist_march_y_ctrl: behavioural 16x8 memory with optional stuck-at-0
// on word 5 bit 3, an expected-op queue for every cycle of a run, and a table of
// run scenarios plus hand sequences for mid-run reset.
module tb_mbist_march_y_ctrl;

`ifdef MBIST_FAIL_LOG_EN
   localparam bit LogEn = 1'b1;
`else
   localparam bit LogEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [3:0] CA;
   logic       we, re, busy, done, fail;
   logic [7:0] datain;
   logic [7:0] dataout = 8'h00;
   logic [1:0] fail_elem;
   logic [3:0] fail_addr;
   logic [7:0] fail_data;

   int tests = 0;
   int failed = 0;

   mbist_march_y_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .CA(CA), .we(we), .datain(datain),
      .re(re), .dataout(dataout), .busy(busy), .done(done), .fail(fail),
      .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data)
   );

   always #5 clk = ~clk;

   // Memory model: write commits at the edge ending the write cycle, registered read.
   logic [7:0] mem [16];
   bit         fault_en = 1'b0;

   function automatic logic [7:0] flt(input logic [3:0] a, input logic [7:0] d);
      return (fault_en && a == 4'd5) ? (d & 8'hF7) : d;
   endfunction

   always @(posedge clk) begin
      if (we) mem[CA] <= flt(CA, datain);
      if (re) dataout <= flt(CA, mem[CA]);
   end

   typedef struct {
      logic [3:0] a;
      logic       w;
      logic       r;
      logic [7:0] d;
   } op_t;

   typedef struct {
      bit         fault;
      int         s1;
      int         s2;
      bit         e_fail;
      logic [1:0] e_elem;
      logic [3:0] e_addr;
      logic [7:0] e_data;
   } vec_t;

   op_t        opq[$];
   logic [7:0] last_d = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int a, input bit w, input logic [7:0] d);
      op_t o;
      o.a = 4'(a);
      o.w = w;
      o.r = !w;
      o.d = d;
      opq.push_back(o);
   endtask

   // Reference March Y op stream, one entry per op cycle.
   task automatic build_ops();
      opq.delete();
      for (int a = 0; a < 16; a++) push(a, 1'b1, 8'h00);
      for (int a = 0; a < 16; a++) begin
         push(a, 1'b0, 8'h00); push(a, 1'b1, 8'hFF); push(a, 1'b0, 8'h00);
      end
      for (int a = 15; a >= 0; a--) begin
         push(a, 1'b0, 8'h00); push(a, 1'b1, 8'h00); push(a, 1'b0, 8'h00);
      end
      for (int a = 0; a < 16; a++) push(a, 1'b0, 8'h00);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_one(input vec_t v, input int idx);
      int         nw, nr, both, busy_err, done_cyc;
      op_t        e;
      logic [7:0] expd;
      fault_en = v.fault;
      build_ops();
      pulse_start();
      nw = 0; nr = 0; both = 0; busy_err = 0; done_cyc = 0;
      chk($sformatf("v%0d_start_clears", idx), {done, fail, fail_elem, fail_addr, fail_data}, 0);
      for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
         if (opq.size() > 0) begin
            e = opq.pop_front();
            expd = e.w ? e.d : last_d;
            if (e.w) last_d = e.d;
            chk($sformatf("v%0d_op%0d", idx, c), {CA, we, re, datain}, {e.a, e.w, e.r, expd});
         end
         if (we) nw++;
         if (re) nr++;
         if (we && re) both++;
         if (done) done_cyc = c;
         else if (c <= 129 && !busy) busy_err++;
         start = (c == v.s1) || (c == v.s2);
         if (done_cyc == 0) @(negedge clk);
      end
      start = 1'b0;
      chk($sformatf("v%0d_done_cycle", idx), done_cyc, 130);
      chk($sformatf("v%0d_we_count", idx), nw, 48);
      chk($sformatf("v%0d_re_count", idx), nr, 80);
      chk($sformatf("v%0d_we_re_overlap", idx), both, 0);
      chk($sformatf("v%0d_busy_gap", idx), busy_err, 0);
      chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
      chk($sformatf("v%0d_fail", idx), fail, v.e_fail);
      chk($sformatf("v%0d_fail_elem", idx), fail_elem, LogEn ? v.e_elem : 2'd0);
      chk($sformatf("v%0d_fail_addr", idx), fail_addr, LogEn ? v.e_addr : 4'd0);
      chk($sformatf("v%0d_fail_data", idx), fail_data, LogEn ? v.e_data : 8'd0);
      // done must be held while idle in DONE
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_held", idx), {done, busy}, 2'b10);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{fault: 1'b0, s1: 0,  s2: 0,  e_fail: 1'b0, e_elem: 2'd0, e_addr: 4'd0, e_data: 8'h00};
      vecs[1] = '{fault: 1'b1, s1: 0,  s2: 0,  e_fail: 1'b1, e_elem: 2'd1, e_addr: 4'd5, e_data: 8'hF7};
      vecs[2] = '{fault: 1'b0, s1: 10, s2: 50, e_fail: 1'b0, e_elem: 2'd0, e_addr: 4'd0, e_data: 8'h00};
      vecs[3] = '{fault: 1'b1, s1: 10, s2: 50, e_fail: 1'b1, e_elem: 2'd1, e_addr: 4'd5, e_data: 8'hF7};

      for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {CA, we, re, datain, busy, done, fail, fail_elem, fail_addr, fail_data}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {busy, done, we, re}, 0);

      for (int i = 0; i < 4; i++) run_one(vecs[i], i);

      // Faulty run aborted by reset at cycle 60 (fail already set by then).
      fault_en = 1'b1;
      pulse_start();
      repeat (59) @(negedge clk);
      chk("pre_reset_fail", fail, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs",
          {CA, we, re, datain, busy, done, fail, fail_elem, fail_addr, fail_data}, 0);
      repeat (2) @(negedge clk);
      chk("no_done_in_reset", {done, busy}, 0);
      rst_n = 1'b1;
      last_d = 8'h00;
      @(negedge clk);
      run_one(vecs[0], 4);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/mbist_march_y_ctrl.md
# mbist_march_y_ctrl

- MBIST initiator that runs the March Y algorithm against the 16×8 synchronous single-port memory and checks every read.
- Drives the memory's address, write-enable, write-data and read-enable pins directly, and compares the registered read data one cycle later.
- Reports busy, done, a sticky pass/fail flag and the first failing access.
- Sits between the chip-level test controller (start/status) and the memory under test.

## Interface

- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, memory word width; background 0 = all zeros, background 1 = all ones
- clk  input  1  single clock, rising edge, shared with the memory
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only when not busy
- CA  output  ADDR_WIDTH  memory address
- we  output  1  memory write enable
- datain  output  DATA_WIDTH  memory write data
- re  output  1  memory read enable
- dataout  input  DATA_WIDTH  memory read data, valid the cycle after re
- busy  output  1  test in progress
- done  output  1  test finished; held until next accepted start
- fail  output  1  sticky mismatch flag; cleared by accepted start
- fail_elem  output  2  March element (0–3) of first mismatch
- fail_addr  output  ADDR_WIDTH  address of first mismatch
- fail_data  output  DATA_WIDTH  read data of first mismatch

## Operation

- The algorithm has four elements:
  - M0 ⇑(w0): ascending.
  - M1 ⇑(r0,w1,r1): ascending.
  - M2 ⇓(r1,w0,r0): descending, from DEPTH-1 down to 0.
  - M3 ⇑(r0): ascending.
- FSM states: IDLE, M0, M1, M2, M3, DRAIN, DONE.
- State transitions:
  - IDLE/DONE + start → M0 with address 0.
  - Each element → the next element after its last op at its final address (DEPTH-1 for ascending, 0 for M2).
  - M3 → DRAIN → DONE.
- An op index (0..2) sequences the three ops at one address in M1/M2. The address advances only after op 2.
- Exactly one op is issued per cycle: either we or re is high, never both. For DEPTH=16 the test issues 128 ops: 48 writes and 80 reads.
- datain is 0 or all-ones according to the op. Outside write cycles it holds its last value.
- Compare pipeline:
  - Each read registers its expected value, element and address.
  - The next cycle compares them against dataout.
  - On the first mismatch: fail←1 and fail_elem/addr/data are captured.
  - Later mismatches keep fail=1 but do not update the captured fields.
- start while busy is ignored.
- An accepted start clears done, fail and the capture fields.
- The memory's own synchronous reset is not driven by this block.

## Timing

- Reset value of every output is 0: CA, we, re, datain, busy, done, fail, fail_elem, fail_addr, fail_data. State returns to IDLE.
- Reset asserted mid-test aborts immediately:
  - we and re drop to 0 asynchronously.
  - No done pulse is produced.
- Cycle numbering: the start sampled high at edge 0 makes cycle 1 the first op (M0 w0 @ address 0).
- Op k is driven during cycle k, for k = 1..128.
- The M3 read of address 15 is issued in cycle 128. Its data is compared in cycle 129 (DRAIN).
- busy is high during cycles 1–129. done rises in cycle 130, and fail is final in the same cycle.
- Write→read of the same address in consecutive cycles (M1 w1→r1) must return the new data. This holds because the memory commits its write at the edge that ends the write cycle.
- Wrap-around: the address counter must never wrap. M2 ends at address 0 and must not decrement to DEPTH-1.

## Configuration

- MBIST_FAIL_LOG_EN:
  - Defined: the fail_elem, fail_addr and fail_data capture registers are built as specified.
  - Undefined: those three outputs are tied to 0; fail, busy and done are unchanged.

## Test plan

- Fault-free memory, start pulse:
  - done rises exactly 130 cycles after start.
  - fail=0.
  - 48 we and 80 re cycles are counted.
  - we and re are never high together.
- Stuck-at-0 on bit 3 of word 5 (bench fault model): fail=1, fail_elem=1, fail_addr=5, fail_data=0xF7; done still rises at cycle 130.
- Address order monitor: CA runs 0..15 in M0, M1 and M3, and 15..0 in M2. Each M1/M2 address receives exactly three consecutive ops.
- rst_n pulled low at cycle 60:
  - All outputs are 0 immediately and busy=0.
  - A new start then completes a clean run in 130 cycles with fail=0.
- Start pulses at cycles 10 and 50 during a run are ignored, giving one run with done at cycle 130. A start in DONE clears done/fail and reruns.
- With MBIST_FAIL_LOG_EN undefined and the stuck-at fault above: fail=1, and fail_elem/fail_addr/fail_data all remain 0.
